// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_BYTES         = 2;
    localparam int DEFAULT_MEM_BYTES = 1024;

endpackage

// File: rtl/instr_mem_loader.sv
// Framed byte-stream program loader; writes the payload to instruction memory from address 0.
// Optional trailing XOR checksum byte enabled by INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        s_byte,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       bytes_loaded,
    output logic              cpu_resetn
);

    localparam int LEN_W = HDR_BYTES * 8;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_full;
    logic               hs;
    logic               restart;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    assign hs       = s_valid && s_ready;
    assign len_full = {len[15:8], s_byte};
    assign restart  = start && (state == IDLE || state == DONE || state == ERROR);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = LEN_HI;
            LEN_HI:            if (hs) state_nxt = LEN_LO;
            LEN_LO: begin
                if (hs) begin
                    if (len_full == '0)
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_nxt = CHK;
`else
                        state_nxt = DONE;
`endif
                    else if (32'(len_full) > 32'(MEM_BYTES) || s_byte[1:0] != 2'b00)
                        state_nxt = ERROR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: begin
                if (hs && bytes_loaded == len - 16'd1)
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK: if (hs) state_nxt = (s_byte == csum) ? DONE : ERROR;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            s_ready      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            bytes_loaded <= '0;
            cpu_resetn   <= 1'b0;
            len          <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state      <= state_nxt;
            done       <= (state_nxt == DONE);
            error      <= (state_nxt == ERROR);
            cpu_resetn <= (state_nxt == DONE);
`ifdef INSTR_LOADER_CHECKSUM_EN
            s_ready    <= (state_nxt == LEN_HI || state_nxt == LEN_LO ||
                           state_nxt == DATA   || state_nxt == CHK);
            busy       <= (state_nxt == LEN_HI || state_nxt == LEN_LO ||
                           state_nxt == DATA   || state_nxt == CHK);
`else
            s_ready    <= (state_nxt == LEN_HI || state_nxt == LEN_LO || state_nxt == DATA);
            busy       <= (state_nxt == LEN_HI || state_nxt == LEN_LO || state_nxt == DATA);
`endif
            mem_we     <= (state == DATA) && hs;

            if (restart)
                bytes_loaded <= '0;
            if (state == LEN_HI && hs)
                len[15:8] <= s_byte;
            if (state == LEN_LO && hs) begin
                len[7:0] <= s_byte;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            // Address and data hold their last values between handshakes.
            if (state == DATA && hs) begin
                mem_addr     <= ADDR_W'(bytes_loaded);
                mem_wdata    <= s_byte;
                bytes_loaded <= bytes_loaded + 16'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum         <= csum ^ s_byte;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (default build; checksum steps under INSTR_LOADER_CHECKSUM_EN).
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] bytes_loaded;
    logic        cpu_resetn;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] wa[$];
    logic [7:0]  wd[$];

    instr_mem_loader #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .s_byte       (s_byte),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bytes_loaded (bytes_loaded),
        .cpu_resetn   (cpu_resetn)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn === 1'b1 && mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_byte  = b;
        for (int i = 0; i < 20; i++) begin
            if (s_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] exp_d[$]);
        check({tag, "_count"}, wa.size(), exp_d.size());
        if (wa.size() == exp_d.size()) begin
            for (int i = 0; i < exp_d.size(); i++) begin
                check({tag, "_addr"}, wa[i], i);
                check({tag, "_data"}, {24'd0, wd[i]}, {24'd0, exp_d[i]});
            end
        end
    endtask

    logic [7:0] img8[$] = '{8'h00, 8'hF0, 8'h00, 8'h93, 8'h40, 8'h01, 8'h01, 8'hB3};
    logic [7:0] img4[$] = '{8'h13, 8'h57, 8'h9B, 8'hDF};
    logic [7:0] img4b[$] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        resetn  = 1'b1;
        start   = 1'b0;
        s_byte  = '0;
        s_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cpu_resetn", cpu_resetn, 0);
        check("rst_bytes_loaded", bytes_loaded, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // 8-byte image
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_s_ready", s_ready, 1);
        send(8'h00); send(8'h08);
        foreach (img8[i]) send(img8[i]);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h00 ^ 8'hF0 ^ 8'h00 ^ 8'h93 ^ 8'h40 ^ 8'h01 ^ 8'h01 ^ 8'hB3);
`else
        check("t1_last_we_with_done", mem_we, 1);
`endif
        check("t1_done", done, 1);
        check("t1_cpu_resetn", cpu_resetn, 1);
        check("t1_s_ready_off", s_ready, 0);
        check("t1_bytes_loaded", bytes_loaded, 8);
        repeat (2) @(posedge clk); #1;
        check_writes("t1", img8);
        wa.delete(); wd.delete();

        // zero length
        pulse_start();
        check("t2_done_cleared", done, 0);
        check("t2_cpu_resetn_cleared", cpu_resetn, 0);
        check("t2_bytes_cleared", bytes_loaded, 0);
        send(8'h00); send(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        check("t2_done", done, 1);
        check("t2_cpu_resetn", cpu_resetn, 1);
        repeat (3) @(posedge clk); #1;
        check("t2_no_writes", wa.size(), 0);

        // oversize header
        pulse_start();
        send(8'h04); send(8'h04);
        check("t3a_error", error, 1);
        check("t3a_cpu_resetn", cpu_resetn, 0);
        check("t3a_s_ready", s_ready, 0);
        check("t3a_done", done, 0);
        pulse_start();
        check("t3a_error_cleared", error, 0);
        check("t3a_relaunch_ready", s_ready, 1);
        // length not a multiple of 4
        send(8'h00); send(8'h06);
        check("t3b_error", error, 1);
        check("t3b_cpu_resetn", cpu_resetn, 0);
        repeat (2) @(posedge clk); #1;
        check("t3_no_writes", wa.size(), 0);
        pulse_start();
        check("t3b_error_cleared", error, 0);
        check("t3b_busy", busy, 1);

        // gapped stream, already in LEN_HI
        send(8'h00); send(8'h04);
        for (int i = 0; i < 4; i++) begin
            send(img4[i]);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    @(posedge clk); #1;
                    check("t4_ready_in_gap", s_ready, 1);
                    check("t4_we_in_gap", mem_we, 0);
                    check("t4_addr_held", mem_addr, i);
                end
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'h13 ^ 8'h57 ^ 8'h9B ^ 8'hDF);
`endif
        check("t4_done", done, 1);
        repeat (2) @(posedge clk); #1;
        check_writes("t4", img4);
        wa.delete(); wd.delete();

        // asynchronous reset mid-load
        pulse_start();
        send(8'h00); send(8'h08);
        send(8'h01); send(8'h02); send(8'h03);
        check("t5_we_before_reset", mem_we, 1);
        #2 resetn = 1'b0;
        #1;
        check("t5_we_async", mem_we, 0);
        check("t5_cpu_resetn_async", cpu_resetn, 0);
        check("t5_bytes_async", bytes_loaded, 0);
        check("t5_s_ready_async", s_ready, 0);
        check("t5_addr_async", mem_addr, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        wa.delete(); wd.delete();
        @(posedge clk); #1;
        pulse_start();
        send(8'h00); send(8'h04);
        foreach (img4b[i]) send(img4b[i]);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
        check("t5_done", done, 1);
        repeat (2) @(posedge clk); #1;
        check_writes("t5", img4b);
        wa.delete(); wd.delete();

`ifdef INSTR_LOADER_CHECKSUM_EN
        pulse_start();
        send(8'h00); send(8'h04);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h44);
        check("t6_good_done", done, 1);
        check("t6_good_cpu_resetn", cpu_resetn, 1);
        pulse_start();
        send(8'h00); send(8'h04);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h45);
        check("t6_bad_error", error, 1);
        check("t6_bad_cpu_resetn", cpu_resetn, 0);
        check("t6_bad_done", done, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
